pcie_ch_line_pack: RTL
======================

// Module: pcie_ch_line_pack
// PURPOSE
//  Per-channel upstream stage of the 4-channel PCIe DMA image path (one instance per quadrant ch0..ch3).
//  Packs a 16-bit RGB565 pixel stream into 128-bit words (8 px/word) and buffers them in a show-ahead FIFO.
//  Serves the downstream channel selector: chN_data_req pops one word, chN_data is the current head word.
//  Raises line_rdy once a full quadrant line (LINE_WORDS words) is buffered; the four line_rdy are ANDed into line_full_flag.
// PARAMETERS
//  LINE_WORDS  80   words per quadrant line (640 px * 16 b / 128 b)
//  DEPTH       256  FIFO depth in 128-bit words; power of 2, >= 2*LINE_WORDS
//  ADDR_W      8    log2(DEPTH)
// PORTS
//  clk        in   1          system clock, shared by pixel and DMA sides
//  rst_n      in   1          synchronous, active-low reset
//  pix_vs     in   1          frame sync, active high; rising edge flushes the block
//  pix_de     in   1          pixel valid
//  pix_data   in   16         RGB565 pixel
//  rd_req     in   1          pop request from the channel selector (chN_data_req)
//  rd_data    out  128        head-of-FIFO word (chN_data)
//  line_rdy   out  1          word_cnt >= LINE_WORDS
//  word_cnt   out  ADDR_W+1   full words currently stored, 0..DEPTH
//  ovf_flag   out  1          sticky: a packed word was dropped because the FIFO was full
//  udf_flag   out  1          sticky: rd_req arrived while the FIFO was empty
// BEHAVIOUR
//  Reset: rd_data=0, line_rdy=0, word_cnt=0, ovf_flag=0, udf_flag=0; pointers, pack counter and vs history cleared.
//  Packing: 3-bit pack counter increments on each pix_de=1 cycle.
//   - First pixel of a word goes to [127:112], eighth pixel to [15:0] (MSB-first).
//   - On the 8th pixel (counter 7->0) the assembled word is written to the FIFO one cycle later.
//   - Pixels are never padded; a partial word is discarded on flush.
//  Write latency: 8th pixel accepted in cycle N -> RAM written at N+1; word_cnt/line_rdy/rd_data reflect it at N+2.
//  Read (FWFT): rd_data always shows the head word.
//   - rd_req=1 with word_cnt>0 in cycle N -> rd_data shows the next word at N+1 and word_cnt decrements at N+1.
//   - rd_req with word_cnt==0: no pointer change, rd_data holds its value, udf_flag<=1.
//   - After the FIFO drains, rd_data keeps the last popped word.
//  Full: a write arriving with word_cnt==DEPTH (and no same-cycle pop) is dropped, ovf_flag<=1.
//   - A write and a pop in the same cycle at full are both performed; word_cnt is unchanged.
//  Simultaneous write+pop at any level: word_cnt unchanged, both pointers advance (mod DEPTH).
//  Pointer wrap: wr_ptr/rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0; word_cnt is kept as a separate counter.
//  line_rdy is registered: line_rdy <= (next word_cnt >= LINE_WORDS).
//  Frame flush: pix_vs is registered; on a detected rising edge (vs & ~vs_d), the next cycle:
//   - pointers, word_cnt and pack counter go to 0, line_rdy=0, ovf_flag=0, udf_flag=0; rd_data keeps its value.
//   - A pixel with pix_de=1 in the edge cycle is discarded; pending writes and pops in that cycle are cancelled.
//  Reset mid-frame: identical to the reset state; no word survives.
//  RAM: simple dual-port, inferred; the read address is pre-fetched so rd_data is valid without a request cycle.
// TESTING
//  T1 reset: hold rst_n=0 for 4 cycles with pix_de toggling -> all outputs 0, word_cnt=0.
//  T2 pack: vs pulse, then 640 px with value=index (0..639) -> word0=0x0000_0001_..._0007; word_cnt=80; line_rdy=1 two cycles after px 639.
//  T3 drain: rd_req held for 80 cycles after T2 -> rd_data sequence word0..word79 in order; line_rdy=0 once word_cnt<80; udf_flag stays 0.
//  T4 concurrent: keep 40 words stored, stream px at 1/cycle and pop every 8th cycle -> word_cnt constant at 40 (+/-1).
//  T5 overflow: write 2064 px without popping -> word_cnt=256, 258th word dropped, ovf_flag=1; a later pop succeeds, rd_data=word0.
//  T6 underflow/flush: rd_req on empty -> udf_flag=1; raise pix_vs mid-line with 3 px pending -> word_cnt=0, flags cleared, next 8 px form word0.

Source files
------------

// File: rtl/pcie_ch_line_pack.sv
// -----------------------------------------------------------------------------
// pcie_ch_line_pack
//
// Per-channel upstream stage of the 4-channel PCIe DMA image path. It packs a
// 16-bit RGB565 pixel stream into 128-bit words, with 8 pixels per word and the
// first pixel at [127:112]. Words are buffered in a show-ahead (FWFT) FIFO built
// on an inferred simple dual-port RAM. line_rdy is raised once a full quadrant
// line is buffered.
//
// Ports
//   clk       in   1         system clock (pixel and DMA sides)
//   rst_n     in   1         synchronous, active-low reset
//   pix_vs    in   1         frame sync; a rising edge flushes the block
//   pix_de    in   1         pixel valid
//   pix_data  in   16        RGB565 pixel
//   rd_req    in   1         pop request from the channel selector
//   rd_data   out  128       head-of-FIFO word (holds the last word once drained)
//   line_rdy  out  1         registered (word_cnt >= LINE_WORDS)
//   word_cnt  out  ADDR_W+1  full words stored, 0..DEPTH
//   ovf_flag  out  1         sticky: a packed word was dropped on a full FIFO
//   udf_flag  out  1         sticky: rd_req arrived while the FIFO was empty
// -----------------------------------------------------------------------------
module pcie_ch_line_pack #(
   parameter int LINE_WORDS = 80,
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_vs,
   input  logic              pix_de,
   input  logic [15:0]       pix_data,
   input  logic              rd_req,
   output logic [127:0]      rd_data,
   output logic              line_rdy,
   output logic [ADDR_W:0]   word_cnt,
   output logic              ovf_flag,
   output logic              udf_flag
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LINE_CNT = (ADDR_W+1)'(LINE_WORDS);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   logic [127:0]      mem [DEPTH];

   logic              vs_d_reg;
   logic [2:0]        pack_cnt_reg;
   logic [111:0]      pack_word_reg;   // first seven pixels of the word in progress
   logic              wr_pend_reg;
   logic [127:0]      wr_word_reg;
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   cnt_reg;
   logic              line_rdy_reg;
   logic              ovf_reg;
   logic              udf_reg;
   logic [127:0]      rd_data_reg;

   logic              flush;
   logic              is_empty;
   logic              is_full;
   logic              do_pop;
   logic              do_wr;
   logic              wr_drop;
   logic              rd_miss;
   logic              head_from_wr;
   logic              head_from_ram;
   logic [ADDR_W-1:0] rd_ptr_inc;
   logic [ADDR_W:0]   cnt_next;

   always_comb begin
      flush    = pix_vs & ~vs_d_reg;
      is_empty = (cnt_reg == '0);
      is_full  = (cnt_reg == FULL_CNT);
      // A flush cancels everything that would otherwise happen in the edge cycle.
      do_pop   = rd_req & ~is_empty & ~flush;
      // At full, a same-cycle pop frees the slot the write lands in.
      do_wr    = wr_pend_reg & ~flush & (~is_full | do_pop);
      wr_drop  = wr_pend_reg & ~flush & is_full & ~do_pop;
      rd_miss  = rd_req & is_empty & ~flush;
      // The head register is refreshed from the write port when the new word
      // becomes the head in this same cycle (empty FIFO, or popping the last
      // word). Otherwise it comes from the RAM at the next read address.
      head_from_wr  = do_wr & (is_empty | (do_pop & (cnt_reg == ONE_CNT)));
      head_from_ram = do_pop & (cnt_reg > ONE_CNT);
      rd_ptr_inc    = rd_ptr_reg + ADDR_W'(1);

      cnt_next = cnt_reg;
      if (flush) begin
         cnt_next = '0;
      end else if (do_wr && !do_pop) begin
         cnt_next = cnt_reg + ONE_CNT;
      end else if (do_pop && !do_wr) begin
         cnt_next = cnt_reg - ONE_CNT;
      end
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_word_reg;
      end
   end

   // Registered read port. The address is the element after the current head,
   // so rd_data is valid without a request cycle. A flush keeps rd_data as it is.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_reg <= '0;
      end else if (head_from_wr) begin
         rd_data_reg <= wr_word_reg;
      end else if (head_from_ram) begin
         rd_data_reg <= mem[rd_ptr_inc];
      end
   end

   // Packing, pointers, occupancy and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_d_reg      <= 1'b0;
         pack_cnt_reg  <= '0;
         pack_word_reg <= '0;
         wr_pend_reg   <= 1'b0;
         wr_word_reg   <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         cnt_reg       <= '0;
         line_rdy_reg  <= 1'b0;
         ovf_reg       <= 1'b0;
         udf_reg       <= 1'b0;
      end else begin
         vs_d_reg <= pix_vs;
         if (flush) begin
            // The pixel presented in the edge cycle is dropped with the partial word.
            pack_cnt_reg <= '0;
            wr_pend_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            line_rdy_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
         end else begin
            if (do_wr) begin
               wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (do_pop) begin
               rd_ptr_reg <= rd_ptr_inc;
            end
            cnt_reg      <= cnt_next;
            line_rdy_reg <= (cnt_next >= LINE_CNT);
            if (wr_drop) begin
               ovf_reg <= 1'b1;
            end
            if (rd_miss) begin
               udf_reg <= 1'b1;
            end

            wr_pend_reg <= 1'b0;
            if (pix_de) begin
               pack_cnt_reg <= pack_cnt_reg + 3'd1;
               if (pack_cnt_reg == 3'd7) begin
                  // Earlier pixels were shifted left, so the first sits on top.
                  wr_word_reg <= {pack_word_reg, pix_data};
                  wr_pend_reg <= 1'b1;
               end else begin
                  pack_word_reg <= {pack_word_reg[95:0], pix_data};
               end
            end
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign line_rdy = line_rdy_reg;
   assign word_cnt = cnt_reg;
   assign ovf_flag = ovf_reg;
   assign udf_flag = udf_reg;

endmodule
